countdown_control: RTL and testbench

Control stage directly upstream of the 9-to-0 BCD countdown counter. It debounces the two raw presence sensors and generates the counter's slow clock. It drives the counter's `Bs`/`Vs`/`Error` inputs from a four-state FSM and reads the counter's `bcd` output back to detect end of countdown. All logic runs on the board clock; the counter runs on `cnt_clock`, which this block produces.

---
 rtl/countdown_control_if.sv | 8 +
 rtl/countdown_control.sv | 95 +++++++++
 tb/tb_countdown_control.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_control_if.sv
// countdown_control_if: link between the control stage and the BCD countdown counter.
interface countdown_control_if;
  logic [3:0] bcd;
  logic       cnt_clock, Bs, Vs, Error, done;
  logic [1:0] state;
  modport master (input bcd, output cnt_clock, Bs, Vs, Error, done, state);
  modport slave (output bcd, input cnt_clock, Bs, Vs, Error, done, state);
endinterface

// File: rtl/countdown_control.sv
// countdown_control: sensor debounce, slow-clock generation and run/done/error FSM
// driving the enables of a 9-to-0 BCD countdown counter.
module countdown_control #(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int DEBOUNCE    = 500_000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                bs_in,
  input  logic                vs_in,
  countdown_control_if.master cif
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int DW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;
  logic [1:0]          s1_q, s2_q, deb_q, deb_d;
  logic [1:0][CW-1:0]  dcnt_q, dcnt_d;
  logic [DW-1:0]       div_q, div_d;
  logic                ck_q, ck_d, wrap, sample, b, v;
  state_t              st_q, st_d;
  logic                src_q, src_d, seen_q, seen_d;
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int k = 0; k < 2; k++) begin
      dcnt_d[k] = (s2_q[k] == deb_q[k] || dcnt_q[k] == DB_LAST) ? '0 : dcnt_q[k] + 1'b1;
      deb_d[k]  = (s2_q[k] != deb_q[k] && dcnt_q[k] == DB_LAST) ? s2_q[k] : deb_q[k];
    end
  end
  assign wrap   = div_q == DIV_LAST;
  assign sample = wrap & ck_q;
  assign div_d  = wrap ? '0 : div_q + 1'b1;
  assign ck_d   = ck_q ^ wrap;
  assign b      = deb_q[0];
  assign v      = deb_q[1];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      dcnt_q <= '0;
      div_q  <= '0;
      ck_q   <= 1'b0;
    end else begin
      s1_q   <= {vs_in, bs_in};
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
      div_q  <= div_d;
      ck_q   <= ck_d;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st_q   <= IDLE;
      src_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      src_q  <= src_d;
      seen_q <= seen_d;
    end
  // bcd is only trusted on the cnt_clock falling toggle, mid-period of the counter
  always_comb begin
    st_d   = st_q;
    src_d  = src_q;
    seen_d = seen_q;
    case (st_q)
      IDLE:
        if (b & v) st_d = ERROR;
        else if (b ^ v) begin
          st_d   = RUN;
          src_d  = ~b;
          seen_d = 1'b0;
        end
      RUN:
        if (b & v) st_d = ERROR;
        else if (sample) begin
          if (cif.bcd != 4'd0) seen_d = 1'b1;
          else if (seen_q) st_d = DONE;
        end
      DONE:    st_d = (b & v) ? ERROR : (!b & !v) ? IDLE : DONE;
      default: st_d = (!b & !v) ? IDLE : ERROR;
    endcase
  end
  always_comb begin
    cif.state     = st_q;
    cif.cnt_clock = ck_q;
    cif.Bs        = (st_q == RUN) & ~src_q;
    cif.Vs        = (st_q == RUN) & src_q;
    cif.Error     = st_q == ERROR;
    cif.done      = st_q == DONE;
  end
endmodule

// File: tb/tb_countdown_control.sv
// tb_countdown_control: directed vectors, corner sequences and a randomized run against
// a rule-level model, with a behavioural BCD countdown counter closing the loop.
module tb_countdown_control;
  localparam int HP = 4;
  localparam int DB = 3;
  logic clock = 1'b0, reset_n = 1'b0, bs_in = 1'b0, vs_in = 1'b0;
  logic [3:0] cnt_m = 4'd0;
  int tests = 0, fails = 0;
  countdown_control_if cif();
  countdown_control #(.HALF_PERIOD(HP), .DEBOUNCE(DB)) dut (
    .clock(clock), .reset_n(reset_n), .bs_in(bs_in), .vs_in(vs_in), .cif(cif.master));
  always #5 clock = ~clock;
  assign cif.bcd = cnt_m;
  always @(posedge cif.cnt_clock)
    cnt_m = cif.Error ? 4'd0 : (cif.Bs | cif.Vs) ? ((cnt_m == 4'd0) ? 4'd9 : cnt_m - 4'd1) : cnt_m;
  typedef struct {
    logic       bs;
    logic       vs;
    int         n;
    logic [5:0] exp;
  } vec_t;
  logic [1:0] ms1, ms2, mdeb, mst;
  logic       msrc, mseen;
  int         n;
  logic [1:0] h[$];
  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask
  function automatic logic [5:0] cur();
    return {cif.state, cif.Bs, cif.Vs, cif.Error, cif.done};
  endfunction
  task automatic outs(input string nm, input logic [1:0] st, input logic [3:0] fl);
    chk(nm, cur(), {st, fl});
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    bs_in = 1'b0;
    vs_in = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask
  task automatic model_reset();
    ms1 = '0; ms2 = '0; mdeb = '0; mst = '0; msrc = 1'b0; mseen = 1'b0; n = 0;
    h.delete();
  endtask
  task automatic model_edge(input logic [1:0] raw);
    logic b, v, smp, all_diff;
    b = mdeb[0];
    v = mdeb[1];
    smp = ((n + 1) % (2 * HP)) == 0;
    case (mst)
      2'd0: if (b && v) mst = 2'd3; else if (b != v) begin mst = 2'd1; msrc = !b; mseen = 1'b0; end
      2'd1: if (b && v) mst = 2'd3; else if (smp) begin
              if (cif.bcd != 4'd0) mseen = 1'b1; else if (mseen) mst = 2'd2;
            end
      2'd2: if (b && v) mst = 2'd3; else if (!b && !v) mst = 2'd0;
      default: if (!b && !v) mst = 2'd0;
    endcase
    h.push_back(ms2);
    if (h.size() > DB) void'(h.pop_front());
    for (int k = 0; k < 2; k++) begin
      all_diff = h.size() == DB;
      foreach (h[j]) if (h[j][k] == mdeb[k]) all_diff = 1'b0;
      if (all_diff) mdeb[k] = ~mdeb[k];
    end
    ms2 = ms1;
    ms1 = raw;
    n++;
  endtask
  function automatic logic [6:0] mexp();
    return {mst, mst == 2'd1 && !msrc, mst == 2'd1 && msrc, mst == 2'd3, mst == 2'd2, ((n / HP) % 2) == 1};
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t vt[11];
    int cyc, bad, seg;
    bit flag, dn_seen;
    logic [3:0] prev;
    logic [3:0] q[$];
    logic pc;
    logic [1:0] raw;
    vt[0]  = '{1'b0, 1'b0, 2, 6'b00_0000};
    vt[1]  = '{1'b1, 1'b0, 5, 6'b00_0000};
    vt[2]  = '{1'b1, 1'b0, 1, 6'b01_1000};
    vt[3]  = '{1'b1, 1'b1, 5, 6'b01_1000};
    vt[4]  = '{1'b1, 1'b1, 1, 6'b11_0010};
    vt[5]  = '{1'b0, 1'b0, 5, 6'b11_0010};
    vt[6]  = '{1'b0, 1'b0, 1, 6'b00_0000};
    vt[7]  = '{1'b0, 1'b1, 6, 6'b01_0100};
    vt[8]  = '{1'b0, 1'b0, 6, 6'b01_0100};
    vt[9]  = '{1'b1, 1'b1, 6, 6'b11_0010};
    vt[10] = '{1'b0, 1'b0, 6, 6'b00_0000};
    // reset with random inputs, then divider phase
    for (int i = 0; i < 4; i++) begin
      bs_in = 1'($urandom);
      vs_in = 1'($urandom);
      tick(1);
      outs("rst_outs", 2'd0, 4'b0000);
      chk("rst_ck", cif.cnt_clock, 0);
    end
    bs_in = 1'b0;
    vs_in = 1'b0;
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk($sformatf("ck_edge%0d", k), cif.cnt_clock, (k / HP) % 2);
    end
    do_reset();
    cnt_m = 4'd0;
    for (int i = 0; i < 11; i++) begin
      bs_in = vt[i].bs;
      vs_in = vt[i].vs;
      tick(vt[i].n);
      chk($sformatf("vec%0d", i), cur(), vt[i].exp);
    end
    // full countdown from sensor B
    do_reset();
    cnt_m = 4'd0;
    bs_in = 1'b1;
    tick(5);
    outs("t2_pre", 2'd0, 4'b0000);
    tick(1);
    outs("t2_run", 2'd1, 4'b1000);
    q.delete();
    prev = cif.bcd;
    cyc = 0;
    while (cyc < 200 && !cif.done) begin
      tick(1);
      cyc++;
      if (cif.bcd != prev) begin
        q.push_back(cif.bcd);
        prev = cif.bcd;
      end
    end
    chk("t2_done", cif.done, 1);
    chk("t2_latency", int'(cyc >= 72 && cyc <= 88), 1);
    bad = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] != 4'(9 - i)) bad++;
    chk("t2_seqlen", q.size(), 10);
    chk("t2_seq", bad, 0);
    outs("t2_donest", 2'd2, 4'b0001);
    bs_in = 1'b0;
    tick(5);
    outs("t2_hold", 2'd2, 4'b0001);
    tick(1);
    outs("t2_idle", 2'd0, 4'b0000);
    // short glitches are rejected
    do_reset();
    flag = 1'b0;
    for (int p = 0; p < 5; p++) begin
      bs_in = 1'b1;
      for (int i = 0; i < 2; i++) begin tick(1); flag |= cif.Bs | (cif.state != 2'd0); end
      bs_in = 1'b0;
      for (int i = 0; i < 2; i++) begin tick(1); flag |= cif.Bs | (cif.state != 2'd0); end
    end
    for (int i = 0; i < 10; i++) begin tick(1); flag |= cif.Bs | (cif.state != 2'd0); end
    chk("t3_glitch", flag, 0);
    // both sensors together from IDLE
    do_reset();
    cnt_m = 4'd7;
    bs_in = 1'b1;
    vs_in = 1'b1;
    tick(6);
    outs("t4_err", 2'd3, 4'b0010);
    pc = cif.cnt_clock;
    flag = 1'b0;
    for (int i = 0; i < 20 && !flag; i++) begin
      tick(1);
      flag = !pc && cif.cnt_clock;
      pc = cif.cnt_clock;
    end
    chk("t4_rise", flag, 1);
    chk("t4_force0", cif.bcd, 0);
    bs_in = 1'b0;
    vs_in = 1'b0;
    tick(6);
    outs("t4_idle", 2'd0, 4'b0000);
    // error during a V run
    do_reset();
    cnt_m = 4'd0;
    dn_seen = 1'b0;
    vs_in = 1'b1;
    tick(6);
    outs("t5_run", 2'd1, 4'b0100);
    flag = 1'b0;
    for (int i = 0; i < 100 && !flag; i++) begin tick(1); dn_seen |= cif.done; flag = cif.bcd == 4'd5; end
    chk("t5_bcd5", flag, 1);
    bs_in = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); dn_seen |= cif.done; end
    outs("t5_err", 2'd3, 4'b0010);
    pc = cif.cnt_clock;
    flag = 1'b0;
    for (int i = 0; i < 20 && !flag; i++) begin
      tick(1);
      dn_seen |= cif.done;
      flag = !pc && cif.cnt_clock;
      pc = cif.cnt_clock;
    end
    chk("t5_rise", flag, 1);
    chk("t5_force0", cif.bcd, 0);
    bs_in = 1'b0;
    vs_in = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(1); dn_seen |= cif.done; end
    outs("t5_idle", 2'd0, 4'b0000);
    chk("t5_nodone", dn_seen, 0);
    // reset pulse mid-run
    do_reset();
    cnt_m = 4'd0;
    bs_in = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 10 && !flag; i++) begin tick(1); flag = cif.state == 2'd1; end
    chk("t6_run", flag, 1);
    flag = 1'b0;
    for (int i = 0; i < 100 && !flag; i++) begin tick(1); flag = cif.bcd == 4'd4; end
    chk("t6_bcd4", flag, 1);
    reset_n = 1'b0;
    #1;
    outs("t6_async", 2'd0, 4'b0000);
    chk("t6_ck", cif.cnt_clock, 0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    outs("t6_wait", 2'd0, 4'b0000);
    tick(1);
    outs("t6_rerun", 2'd1, 4'b1000);
    // randomized run against the rule-level model
    do_reset();
    model_reset();
    seg = 0;
    raw = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        raw = 2'($urandom_range(0, 3));
        seg = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(1, 12);
      end
      seg--;
      bs_in = raw[0];
      vs_in = raw[1];
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        model_reset();
        tick(1);
        chk("rnd_rst", {cur(), cif.cnt_clock}, mexp());
        reset_n = 1'b1;
      end else begin
        model_edge(raw);
        tick(1);
        chk("rnd", {cur(), cif.cnt_clock}, mexp());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
